// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART responder for the E stage: decodes the 0x8xxx_xxxx I/O window,
// buffers TX/RX bytes in small FIFOs and keeps a free-running cycle counter.
module uart_mmio_ctrl #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [5:0]  opcodeE,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] rd2E,
    output logic        UARTCtr,
    output logic [31:0] UARTCtrOut,
    output logic [7:0]  TxData,
    output logic        DataInValid,
    input  logic        DataInReady,
    input  logic [7:0]  UARTDataOut,
    input  logic        DataOutValid,
    output logic        DataOutReady
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [5:0] REG_TX_STAT = 6'h00;
    localparam logic [5:0] REG_RX_STAT = 6'h01;
    localparam logic [5:0] REG_RX_DATA = 6'h02;
    localparam logic [5:0] REG_TX_DATA = 6'h03;
    localparam logic [5:0] REG_CYCLE   = 6'h04;
    localparam logic [5:0] REG_OVF_CLR = 6'h05;

    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam int ONE = 1;
    localparam logic [TXW-1:0] TX_PTR_ONE = ONE[TXW-1:0];
    localparam logic [RXW-1:0] RX_PTR_ONE = ONE[RXW-1:0];
    localparam logic [TXW:0]   TX_CNT_ONE = ONE[TXW:0];
    localparam logic [RXW:0]   RX_CNT_ONE = ONE[RXW:0];
    localparam logic [TXW:0]   TX_FULL    = TX_DEPTH[TXW:0];
    localparam logic [RXW:0]   RX_FULL    = RX_DEPTH[RXW:0];

    logic [7:0]     r_txMem [TX_DEPTH];
    logic [TXW-1:0] r_txRd;
    logic [TXW-1:0] r_txWr;
    logic [TXW:0]   r_txCount;
    logic [7:0]     r_rxMem [RX_DEPTH];
    logic [RXW-1:0] r_rxRd;
    logic [RXW-1:0] r_rxWr;
    logic [RXW:0]   r_rxCount;
    logic           r_overflow;
    logic [31:0]    r_cycle;

    logic       w_isLoad;
    logic       w_isStore;
    logic       w_ioHit;
    logic [5:0] w_offset;
    logic       w_txFull;
    logic       w_txEmpty;
    logic       w_rxFull;
    logic       w_rxEmpty;
    logic       w_txPush;
    logic       w_txOverflow;
    logic       w_txPop;
    logic       w_rxPush;
    logic       w_rxPop;
    logic       w_cycleClear;
    logic       w_ovfClear;
    logic [7:0] w_rxHead;
    logic       w_unused;

    // Only the I/O nibble and the word offset take part in decode.
    assign w_unused  = ^{ALUOutE[27:8], ALUOutE[1:0], rd2E[31:8]};
    assign w_isLoad  = (opcodeE == OP_LB) || (opcodeE == OP_LW) || (opcodeE == OP_LBU);
    assign w_isStore = (opcodeE == OP_SB) || (opcodeE == OP_SW);
    assign w_ioHit   = (ALUOutE[31:28] == 4'h8);
    assign w_offset  = ALUOutE[7:2];

    assign w_txFull  = (r_txCount == TX_FULL);
    assign w_txEmpty = (r_txCount == '0);
    assign w_rxFull  = (r_rxCount == RX_FULL);
    assign w_rxEmpty = (r_rxCount == '0);

    assign w_txPush     = w_isStore && w_ioHit && (w_offset == REG_TX_DATA) && !stall && !w_txFull;
    assign w_txOverflow = w_isStore && w_ioHit && (w_offset == REG_TX_DATA) && !stall && w_txFull;
    assign w_txPop      = DataInValid && DataInReady;
    assign w_rxPush     = DataOutValid && !w_rxFull;
    assign w_rxPop      = w_isLoad && w_ioHit && (w_offset == REG_RX_DATA) && !stall && !w_rxEmpty;
    assign w_cycleClear = w_isStore && w_ioHit && (w_offset == REG_CYCLE);
    assign w_ovfClear   = w_isStore && w_ioHit && (w_offset == REG_OVF_CLR);

    assign DataInValid  = !reset && !w_txEmpty;
    assign TxData       = DataInValid ? r_txMem[r_txRd] : 8'h00;
    assign DataOutReady = reset || !w_rxFull;
    assign UARTCtr      = !reset && w_isLoad && w_ioHit;
    assign w_rxHead     = r_rxMem[r_rxRd];

    always_comb begin
        UARTCtrOut = 32'h0;
        if (UARTCtr) begin
            case (w_offset)
                REG_TX_STAT: UARTCtrOut = {31'h0, !w_txFull};
                REG_RX_STAT: UARTCtrOut = {30'h0, r_overflow, !w_rxEmpty};
                REG_RX_DATA: begin
                    if (!w_rxEmpty) begin
                        UARTCtrOut = (opcodeE == OP_LB) ? {{24{w_rxHead[7]}}, w_rxHead}
                                                        : {24'h0, w_rxHead};
                    end
                end
                REG_CYCLE:   UARTCtrOut = r_cycle;
                default:     UARTCtrOut = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_txRd     <= '0;
            r_txWr     <= '0;
            r_txCount  <= '0;
            r_rxRd     <= '0;
            r_rxWr     <= '0;
            r_rxCount  <= '0;
            r_overflow <= 1'b0;
            r_cycle    <= 32'h0;
        end else begin
            if (w_txPush) r_txWr <= r_txWr + TX_PTR_ONE;
            if (w_txPop)  r_txRd <= r_txRd + TX_PTR_ONE;
            case ({w_txPush, w_txPop})
                2'b10:   r_txCount <= r_txCount + TX_CNT_ONE;
                2'b01:   r_txCount <= r_txCount - TX_CNT_ONE;
                default: r_txCount <= r_txCount;
            endcase
            if (w_rxPush) r_rxWr <= r_rxWr + RX_PTR_ONE;
            if (w_rxPop)  r_rxRd <= r_rxRd + RX_PTR_ONE;
            case ({w_rxPush, w_rxPop})
                2'b10:   r_rxCount <= r_rxCount + RX_CNT_ONE;
                2'b01:   r_rxCount <= r_rxCount - RX_CNT_ONE;
                default: r_rxCount <= r_rxCount;
            endcase
            if (w_txOverflow)    r_overflow <= 1'b1;
            else if (w_ovfClear) r_overflow <= 1'b0;
            r_cycle <= w_cycleClear ? 32'h0 : r_cycle + 32'd1;
        end
    end

    // Storage needs no reset: the pointers and counts decide what is live.
    always_ff @(posedge clk) begin
        if (w_txPush) r_txMem[r_txWr] <= rd2E[7:0];
        if (w_rxPush) r_rxMem[r_rxWr] <= UARTDataOut;
    end

endmodule
